// File: rtl/xbar_port_arbiter_pkg.sv
// Shared definitions for the crossbar column arbiters: FSM encoding,
// default sizing and a constant-evaluable clog2.
package xbar_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_ACK = 2'd1,
    WAIT_REL = 2'd2
  } state_t;

  localparam int N_MASTERS_DEF = 4;
  localparam int TIMEOUT_DEF   = 255;

  // Smallest r with 2**r >= n; used to size master indices.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/xbar_port_arbiter_if.sv
// Request/grant bundle between the masters of one crossbar column and the
// column's arbiter.
//
// Handshake: m_req[i] is a level; master i raises it and holds it for the
// whole transaction, dropping it to end the transaction (or to abort before
// s_ack). s_ack is the slave's acknowledge seen through the enabled
// crosspoint and only matters while the arbiter waits for it. grant is the
// one-hot crosspoint enable; it stays high from grant until the master drops
// its request, the watchdog fires, or reset.
interface xbar_port_arbiter_if
  import xbar_pkg::*;
#(
  parameter int N_MASTERS = N_MASTERS_DEF,
  parameter int ID_W      = clog2(N_MASTERS)
);
  logic [N_MASTERS-1:0] m_req;
  logic                 s_ack;
  logic [N_MASTERS-1:0] grant;
  logic [ID_W-1:0]      grant_id;
  logic                 conn_active;
  logic                 timeout_err;
  logic [ID_W-1:0]      err_id;
  state_t               state_dbg;

  // Arbiter side of the column.
  modport slave (
    input  m_req, s_ack,
    output grant, grant_id, conn_active, timeout_err, err_id, state_dbg
  );

  // Requester / observer side.
  modport master (
    output m_req, s_ack,
    input  grant, grant_id, conn_active, timeout_err, err_id, state_dbg
  );
endinterface

// File: rtl/xbar_port_arbiter_rr_pick.sv
// Combinational round-robin picker: returns the first requesting index at or
// after ptr, wrapping at N_MASTERS. Shared by all four column arbiters.
module rr_pick
  import xbar_pkg::*;
#(
  parameter int N_MASTERS = N_MASTERS_DEF,
  parameter int ID_W      = clog2(N_MASTERS)
) (
  input  logic [N_MASTERS-1:0] req,
  input  logic [ID_W-1:0]      ptr,
  output logic [ID_W-1:0]      winner,
  output logic                 any
);
  localparam int SW = ID_W + 1;
  localparam logic [SW-1:0] N_EXT = SW'(N_MASTERS);

  // Scan from the lowest priority slot down so the highest priority hit wins.
  always_comb begin
    winner = '0;
    any    = 1'b0;
    for (int i = N_MASTERS - 1; i >= 0; i--) begin
      logic [SW-1:0] sum;
      sum = {1'b0, ptr} + SW'(i);
      if (sum >= N_EXT) sum = sum - N_EXT;
      if (req[sum[ID_W-1:0]]) begin
        winner = sum[ID_W-1:0];
        any    = 1'b1;
      end
    end
  end
endmodule

// File: rtl/xbar_port_arbiter.sv
// Round-robin arbiter for one slave port of the 4x4 crossbar. Holds a one-hot
// crosspoint enable for a whole req/ack transaction, forces one idle cycle
// between grants so enables never overlap, and drops a grant whose slave
// never acknowledges.
module xbar_port_arbiter
  import xbar_pkg::*;
#(
  parameter int N_MASTERS = N_MASTERS_DEF,
  parameter int ID_W      = clog2(N_MASTERS),
  parameter int TIMEOUT   = TIMEOUT_DEF,
  parameter int CNT_W     = 8
) (
  input logic               clk,
  input logic               reset,
  xbar_port_arbiter_if.slave bus
);
  localparam bit              TO_EN   = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [ID_W-1:0]  LAST_ID = ID_W'(N_MASTERS - 1);

  state_t                state_q,    state_d;
  logic [ID_W-1:0]       rr_ptr_q,   rr_ptr_d;
  logic [CNT_W-1:0]      cnt_q,      cnt_d;
  logic [N_MASTERS-1:0]  grant_q,    grant_d;
  logic [ID_W-1:0]       grant_id_q, grant_id_d;
  logic                  conn_q,     conn_d;
  logic                  terr_q,     terr_d;
  logic [ID_W-1:0]       err_id_q,   err_id_d;

  logic [ID_W-1:0]       pick_id;
  logic                  pick_any;
  logic                  owner_req;

  rr_pick #(
    .N_MASTERS (N_MASTERS),
    .ID_W      (ID_W)
  ) u_pick (
    .req    (bus.m_req),
    .ptr    (rr_ptr_q),
    .winner (pick_id),
    .any    (pick_any)
  );

  assign owner_req = bus.m_req[grant_id_q];

  // Next-state and next-output logic for the grant FSM and watchdog.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    cnt_d      = cnt_q;
    grant_d    = grant_q;
    grant_id_d = grant_id_q;
    conn_d     = conn_q;
    terr_d     = 1'b0;
    err_id_d   = err_id_q;

    case (state_q)
      IDLE: begin
        grant_d = '0;
        conn_d  = 1'b0;
        if (pick_any) begin
          grant_d[pick_id] = 1'b1;
          grant_id_d       = pick_id;
          conn_d           = 1'b1;
          cnt_d            = '0;
          rr_ptr_d         = (pick_id == LAST_ID) ? '0 : pick_id + ID_W'(1);
          state_d          = WAIT_ACK;
        end
      end

      WAIT_ACK: begin
        cnt_d = cnt_q + CNT_W'(1);
        // Abort beats ack and timeout: the master has already walked away.
        if (!owner_req) begin
          grant_d = '0;
          conn_d  = 1'b0;
          state_d = IDLE;
        end else if (bus.s_ack) begin
          state_d = WAIT_REL;
        end else if (TO_EN && (cnt_q == TO_LAST)) begin
          terr_d   = 1'b1;
          err_id_d = grant_id_q;
          grant_d  = '0;
          conn_d   = 1'b0;
          state_d  = IDLE;
        end
      end

      WAIT_REL: begin
        // Read data flows here; only the master's release ends the grant.
        if (!owner_req) begin
          grant_d = '0;
          conn_d  = 1'b0;
          state_d = IDLE;
        end
      end

      default: begin
        grant_d = '0;
        conn_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs; reset clears the column immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      cnt_q      <= '0;
      grant_q    <= '0;
      grant_id_q <= '0;
      conn_q     <= 1'b0;
      terr_q     <= 1'b0;
      err_id_q   <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      cnt_q      <= cnt_d;
      grant_q    <= grant_d;
      grant_id_q <= grant_id_d;
      conn_q     <= conn_d;
      terr_q     <= terr_d;
      err_id_q   <= err_id_d;
    end
  end

  assign bus.grant       = grant_q;
  assign bus.grant_id    = grant_id_q;
  assign bus.conn_active = conn_q;
  assign bus.timeout_err = terr_q;
  assign bus.err_id      = err_id_q;
  assign bus.state_dbg   = state_q;

endmodule

// File: tb/tb_xbar_port_arbiter.sv
// Bench for xbar_port_arbiter: directed scenarios with literal expectations,
// plus a transaction-level reference model compared on every cycle.
module tb_xbar_port_arbiter;
  import xbar_pkg::*;

  localparam int N   = 4;
  localparam int IDW = 2;
  localparam int TO  = 4;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  xbar_port_arbiter_if #(.N_MASTERS(N), .ID_W(IDW)) bus ();

  xbar_port_arbiter #(
    .N_MASTERS (N),
    .ID_W      (IDW),
    .TIMEOUT   (TO),
    .CNT_W     (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Clock
  always #5 clk = ~clk;

  // Reference model: who owns the column, whether the slave has answered,
  // how many cycles the owner has waited, and the next search start.
  typedef struct {
    int owner;
    int ptr;
    int age;
    bit acked;
    bit terr;
    int err_id;
  } mdl_t;

  mdl_t mdl;

  function automatic mdl_t mdl_reset();
    mdl_t s;
    s.owner  = -1;
    s.ptr    = 0;
    s.age    = 0;
    s.acked  = 1'b0;
    s.terr   = 1'b0;
    s.err_id = 0;
    return s;
  endfunction

  function automatic mdl_t model_next(input mdl_t s, input logic [N-1:0] req,
                                      input logic ack);
    mdl_t n;
    int   w;
    int   c;
    n      = s;
    n.terr = 1'b0;
    if (s.owner < 0) begin
      w = -1;
      for (int k = 0; k < N; k++) begin
        c = (s.ptr + k) % N;
        if (w < 0 && req[c[IDW-1:0]]) w = c;
      end
      if (w >= 0) begin
        n.owner = w;
        n.ptr   = (w + 1) % N;
        n.age   = 0;
        n.acked = 1'b0;
      end
    end else if (!req[s.owner[IDW-1:0]]) begin
      n.owner = -1;
    end else if (!s.acked) begin
      if (ack) begin
        n.acked = 1'b1;
      end else begin
        n.age = s.age + 1;
        if (TO != 0 && n.age == TO) begin
          n.terr   = 1'b1;
          n.err_id = s.owner;
          n.owner  = -1;
        end
      end
    end
    return n;
  endfunction

  function automatic logic [N-1:0] exp_grant(input mdl_t s);
    logic [N-1:0] one;
    one = 1;
    return (s.owner >= 0) ? (one << s.owner) : '0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Full output comparison against the model.
  task automatic compare_all();
    chk("grant",       32'(bus.grant),       32'(exp_grant(mdl)));
    chk("conn_active", 32'(bus.conn_active), 32'(mdl.owner >= 0));
    chk("timeout_err", 32'(bus.timeout_err), 32'(mdl.terr));
    chk("err_id",      32'(bus.err_id),      32'(mdl.err_id));
    if (mdl.owner >= 0) chk("grant_id", 32'(bus.grant_id), 32'(mdl.owner));
    chk("grant_onehot0", 32'($onehot0(bus.grant)), 32'd1);
  endtask

  // Driver: advance one clock, step the model with the inputs the DUT saw,
  // then compare just after the edge.
  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      if (!reset) mdl = mdl_reset();
      else        mdl = model_next(mdl, bus.m_req, bus.s_ack);
      #1;
      compare_all();
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    mdl   = mdl_reset();
    #1;
    compare_all();
    cyc(1);
    reset = 1'b1;
    cyc(1);
  endtask

  initial begin
    bus.m_req = '0;
    bus.s_ack = 1'b0;
    reset     = 1'b0;
    mdl       = mdl_reset();
    #2;
    compare_all();
    chk("rst_grant",    32'(bus.grant),       32'h0);
    chk("rst_grant_id", 32'(bus.grant_id),    32'h0);
    chk("rst_conn",     32'(bus.conn_active), 32'h0);
    chk("rst_terr",     32'(bus.timeout_err), 32'h0);
    chk("rst_err_id",   32'(bus.err_id),      32'h0);
    chk("rst_state",    32'(bus.state_dbg),   32'(IDLE));
    cyc(2);
    reset = 1'b1;
    cyc(2);

    // Single request, ack, hold through read phase, release.
    bus.m_req = 4'b0010;
    cyc(1);
    chk("single_grant",    32'(bus.grant),    32'h2);
    chk("single_grant_id", 32'(bus.grant_id), 32'd1);
    bus.s_ack = 1'b1;
    cyc(1);
    bus.s_ack = 1'b0;
    chk("single_state_rel", 32'(bus.state_dbg), 32'(WAIT_REL));
    cyc(2);
    chk("single_held", 32'(bus.grant), 32'h2);
    bus.m_req = 4'b0000;
    cyc(1);
    chk("single_released", 32'(bus.grant), 32'h0);
    chk("single_conn_off", 32'(bus.conn_active), 32'h0);

    // Fairness from a fresh pointer: 0,1,2,3,0 with one idle cycle between.
    do_reset();
    for (int k = 0; k < 5; k++) begin
      logic [N-1:0] one;
      one = 1;
      bus.m_req = 4'b1111;
      cyc(1);
      chk("fair_grant_id", 32'(bus.grant_id), 32'(k % N));
      bus.s_ack = 1'b1;
      cyc(1);
      bus.s_ack = 1'b0;
      bus.m_req = 4'b1111 & ~(one << (k % N));
      cyc(1);
      chk("fair_gap", 32'(bus.grant), 32'h0);
    end
    bus.m_req = '0;
    cyc(1);

    // Wrap and skip: last grant 2 -> pointer 3; 0101 goes to 0, then 2.
    bus.m_req = 4'b0100;
    cyc(1);
    chk("wrap_pre_id", 32'(bus.grant_id), 32'd2);
    bus.s_ack = 1'b1;
    cyc(1);
    bus.s_ack = 1'b0;
    bus.m_req = 4'b0000;
    cyc(1);
    bus.m_req = 4'b0101;
    cyc(1);
    chk("wrap_first", 32'(bus.grant), 32'h1);
    bus.s_ack = 1'b1;
    cyc(1);
    bus.s_ack = 1'b0;
    bus.m_req = 4'b0100;
    cyc(1);
    bus.m_req = 4'b0101;
    cyc(1);
    chk("skip_second", 32'(bus.grant), 32'h4);
    chk("skip_second_id", 32'(bus.grant_id), 32'd2);
    bus.s_ack = 1'b1;
    cyc(1);
    bus.s_ack = 1'b0;
    bus.m_req = 4'b0000;
    cyc(1);

    // Watchdog: no ack from master 3's slave.
    bus.m_req = 4'b1000;
    cyc(1);
    chk("to_grant", 32'(bus.grant), 32'h8);
    cyc(3);
    chk("to_not_yet", 32'(bus.timeout_err), 32'h0);
    chk("to_still_held", 32'(bus.grant), 32'h8);
    cyc(1);
    chk("to_pulse", 32'(bus.timeout_err), 32'h1);
    chk("to_err_id", 32'(bus.err_id), 32'd3);
    chk("to_dropped", 32'(bus.grant), 32'h0);
    cyc(1);
    chk("to_pulse_end", 32'(bus.timeout_err), 32'h0);
    chk("to_regrant", 32'(bus.grant), 32'h8);
    bus.m_req = 4'b0000;
    cyc(1);
    chk("abort_after_to", 32'(bus.grant), 32'h0);

    // Ack arriving on the expiry cycle wins.
    bus.m_req = 4'b0001;
    cyc(1);
    cyc(3);
    bus.s_ack = 1'b1;
    cyc(1);
    bus.s_ack = 1'b0;
    chk("ackwin_no_err", 32'(bus.timeout_err), 32'h0);
    chk("ackwin_state", 32'(bus.state_dbg), 32'(WAIT_REL));
    chk("ackwin_held", 32'(bus.grant), 32'h1);
    cyc(2);
    chk("ackwin_still_held", 32'(bus.grant), 32'h1);
    chk("ackwin_err_id_kept", 32'(bus.err_id), 32'd3);
    bus.m_req = 4'b0000;
    cyc(1);

    // Abort while waiting for ack.
    bus.m_req = 4'b0010;
    cyc(1);
    chk("abort_grant", 32'(bus.grant), 32'h2);
    bus.m_req = 4'b0000;
    cyc(1);
    chk("abort_dropped", 32'(bus.grant), 32'h0);
    chk("abort_no_err", 32'(bus.timeout_err), 32'h0);
    chk("abort_state", 32'(bus.state_dbg), 32'(IDLE));

    // Asynchronous reset in the read phase.
    bus.m_req = 4'b0100;
    cyc(1);
    bus.s_ack = 1'b1;
    cyc(1);
    bus.s_ack = 1'b0;
    #2;
    reset = 1'b0;
    mdl   = mdl_reset();
    #1;
    compare_all();
    chk("async_rst_grant", 32'(bus.grant), 32'h0);
    chk("async_rst_conn", 32'(bus.conn_active), 32'h0);
    chk("async_rst_err_id", 32'(bus.err_id), 32'h0);
    bus.m_req = 4'b1111;
    cyc(1);
    reset = 1'b1;
    cyc(1);
    chk("post_rst_grant", 32'(bus.grant), 32'h1);
    chk("post_rst_id", 32'(bus.grant_id), 32'd0);
    bus.m_req = 4'b0000;
    cyc(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
